// File: rtl/dual_issue_fetch_buffer.sv
// dual_issue_fetch_buffer
//   Decoupling instruction queue between a 2-wide fetch stage and a 2-slot
//   decode stage. Fetch pushes 0-2 {pc, instr} pairs per cycle, compacted into
//   consecutive entries. Decode sees the two oldest entries combinationally and
//   consumes 0-2 per cycle in program order. A mispredict flush empties the queue.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset               synchronous, active-low; highest priority
//   flush_i             discard all entries; same-cycle enq/deq ignored
//   enq_valid{0,1}_i    fetch slot valids (slot 0 older)
//   enq_pc{0,1}_i       fetch slot PCs
//   enq_instr{0,1}_i    fetch slot instructions
//   enq_ready_o         at least two free entries (from registered count only)
//   deq_valid{0,1}_o    decode slot valids (slot 0 oldest)
//   deq_pc{0,1}_o       decode slot PCs, 0 when invalid
//   deq_instr{0,1}_o    decode slot instructions, NOP when invalid
//   deq_count_i         entries consumed by decode this cycle (3 acts as 2)
//   count_o             current occupancy
module dual_issue_fetch_buffer #(
    parameter int unsigned      DEPTH = 8,
    parameter int unsigned      XLEN  = 32,
    parameter logic [XLEN-1:0]  NOP   = XLEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       enq_valid0_i,
    input  logic [XLEN-1:0]            enq_pc0_i,
    input  logic [XLEN-1:0]            enq_instr0_i,
    input  logic                       enq_valid1_i,
    input  logic [XLEN-1:0]            enq_pc1_i,
    input  logic [XLEN-1:0]            enq_instr1_i,
    output logic                       enq_ready_o,
    output logic                       deq_valid0_o,
    output logic [XLEN-1:0]            deq_pc0_o,
    output logic [XLEN-1:0]            deq_instr0_o,
    output logic                       deq_valid1_o,
    output logic [XLEN-1:0]            deq_pc1_o,
    output logic [XLEN-1:0]            deq_instr1_o,
    input  logic [1:0]                 deq_count_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_enq_ready;
    logic [1:0]      w_n_enq;
    logic [1:0]      w_deq_req;
    logic [1:0]      w_n_deq;
    logic [AW-1:0]   w_head1;
    logic [AW-1:0]   w_tail_slot1;

    always_comb begin
        // NOTE: every signal gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        w_enq_ready  = (r_count <= CW'(DEPTH - 2));
        w_n_enq      = 2'd0;
        if (w_enq_ready) begin
            w_n_enq = {1'b0, enq_valid0_i} + {1'b0, enq_valid1_i};
        end
        w_deq_req    = (deq_count_i == 2'd3) ? 2'd2 : deq_count_i;
        // Never pop more than is held; clamps to 0 or 1 near empty.
        w_n_deq      = w_deq_req;
        if (r_count < CW'(w_deq_req)) begin
            w_n_deq = r_count[1:0];
        end
        w_head1      = r_head + AW'(1);
        // Slot 1 lands at tail only when slot 0 is absent (compaction).
        w_tail_slot1 = enq_valid0_i ? r_tail + AW'(1) : r_tail;
    end

    // NOTE: the entry array has no reset; occupancy alone decides which
    // entries are live, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (reset && !flush_i && w_enq_ready) begin
            if (enq_valid0_i) begin
                r_pc[r_tail]    <= enq_pc0_i;
                r_instr[r_tail] <= enq_instr0_i;
            end
            if (enq_valid1_i) begin
                r_pc[w_tail_slot1]    <= enq_pc1_i;
                r_instr[w_tail_slot1] <= enq_instr1_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_n_deq);
            r_tail  <= r_tail + AW'(w_n_enq);
            r_count <= r_count + CW'(w_n_enq) - CW'(w_n_deq);
        end
    end

    assign enq_ready_o  = w_enq_ready;
    assign count_o      = r_count;
    assign deq_valid0_o = (r_count != '0);
    assign deq_valid1_o = (r_count >= CW'(2));
    assign deq_pc0_o    = deq_valid0_o ? r_pc[r_head]     : '0;
    assign deq_instr0_o = deq_valid0_o ? r_instr[r_head]  : NOP;
    assign deq_pc1_o    = deq_valid1_o ? r_pc[w_head1]    : '0;
    assign deq_instr1_o = deq_valid1_o ? r_instr[w_head1] : NOP;

endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Self-checking bench for dual_issue_fetch_buffer: a queue-based reference
// model checked against the DUT on every falling edge, directed scenarios with
// literal expectations, then randomized traffic with flushes and resets.
module tb_dual_issue_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        enq_valid0_i, enq_valid1_i;
    logic [31:0] enq_pc0_i, enq_instr0_i, enq_pc1_i, enq_instr1_i;
    logic        enq_ready_o;
    logic        deq_valid0_o, deq_valid1_o;
    logic [31:0] deq_pc0_o, deq_instr0_o, deq_pc1_o, deq_instr1_o;
    logic [1:0]  deq_count_i;
    logic [3:0]  count_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    dual_issue_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .enq_valid0_i (enq_valid0_i),
        .enq_pc0_i    (enq_pc0_i),
        .enq_instr0_i (enq_instr0_i),
        .enq_valid1_i (enq_valid1_i),
        .enq_pc1_i    (enq_pc1_i),
        .enq_instr1_i (enq_instr1_i),
        .enq_ready_o  (enq_ready_o),
        .deq_valid0_o (deq_valid0_o),
        .deq_pc0_o    (deq_pc0_o),
        .deq_instr0_o (deq_instr0_o),
        .deq_valid1_o (deq_valid1_o),
        .deq_pc1_o    (deq_pc1_o),
        .deq_instr1_o (deq_instr1_o),
        .deq_count_i  (deq_count_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    // Reference model: program-ordered list of {pc, instr}.
    logic [63:0] mq[$];

    always @(posedge clk) begin
        int sz;
        int req;
        int ndeq;
        sz = mq.size();
        if (!reset || flush_i) begin
            mq.delete();
        end else begin
            req  = (deq_count_i == 2'd3) ? 2 : int'(deq_count_i);
            ndeq = (req < sz) ? req : sz;
            for (int i = 0; i < ndeq; i++) void'(mq.pop_front());
            if (DEPTH - sz >= 2) begin
                if (enq_valid0_i) mq.push_back({enq_pc0_i, enq_instr0_i});
                if (enq_valid1_i) mq.push_back({enq_pc1_i, enq_instr1_i});
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        if (chk_en) begin
            sz = mq.size();
            check("count",  64'(count_o),      64'(sz));
            check("ready",  64'(enq_ready_o),  64'(DEPTH - sz >= 2));
            check("valid0", 64'(deq_valid0_o), 64'(sz >= 1));
            check("valid1", 64'(deq_valid1_o), 64'(sz >= 2));
            check("pc0",    64'(deq_pc0_o),    (sz >= 1) ? 64'(mq[0][63:32]) : 64'(0));
            check("instr0", 64'(deq_instr0_o), (sz >= 1) ? 64'(mq[0][31:0])  : 64'(NOP));
            check("pc1",    64'(deq_pc1_o),    (sz >= 2) ? 64'(mq[1][63:32]) : 64'(0));
            check("instr1", 64'(deq_instr1_o), (sz >= 2) ? 64'(mq[1][31:0])  : 64'(NOP));
        end
    end

    task automatic cyc(input logic rst_v, input logic fl,
                       input logic v0, input logic [31:0] pc0, input logic [31:0] i0,
                       input logic v1, input logic [31:0] pc1, input logic [31:0] i1,
                       input logic [1:0] dc);
        reset        = rst_v;
        flush_i      = fl;
        enq_valid0_i = v0;
        enq_pc0_i    = pc0;
        enq_instr0_i = i0;
        enq_valid1_i = v1;
        enq_pc1_i    = pc1;
        enq_instr1_i = i1;
        deq_count_i  = dc;
        @(posedge clk);
        #1;
    endtask

    // Convenience: push a pair (or single) with derived instructions.
    task automatic push(input logic v0, input logic [31:0] pc0,
                        input logic v1, input logic [31:0] pc1,
                        input logic [1:0] dc, input logic fl);
        cyc(1'b1, fl, v0, pc0, mk_instr(pc0), v1, pc1, mk_instr(pc1), dc);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] exp_pc;

        // Reset held two cycles while fetch pushes.
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 32'h1, 1'b1, 32'h104, 32'h2, 2'd0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 32'h108, 32'h3, 1'b1, 32'h10C, 32'h4, 2'd0);
        check("rst_count",  64'(count_o),      64'd0);
        check("rst_ready",  64'(enq_ready_o),  64'd1);
        check("rst_instr0", 64'(deq_instr0_o), 64'h13);
        check("rst_pc0",    64'(deq_pc0_o),    64'd0);

        // Fill with pairs, no dequeue.
        push(1, 32'h0,  1, 32'h4,  2'd0, 0); check("fill_c2", 64'(count_o), 64'd2);
        push(1, 32'h8,  1, 32'hC,  2'd0, 0); check("fill_c4", 64'(count_o), 64'd4);
        push(1, 32'h10, 1, 32'h14, 2'd0, 0); check("fill_c6", 64'(count_o), 64'd6);
        check("fill_rdy6", 64'(enq_ready_o), 64'd1);
        push(1, 32'h18, 1, 32'h1C, 2'd0, 0); check("fill_c8", 64'(count_o), 64'd8);
        check("fill_rdy8", 64'(enq_ready_o), 64'd0);
        push(1, 32'h20, 1, 32'h24, 2'd0, 0); check("drop_c8", 64'(count_o), 64'd8);
        check("fill_pc0", 64'(deq_pc0_o), 64'h0);
        check("fill_pc1", 64'(deq_pc1_o), 64'h4);
        push(0, 32'h0,  0, 32'h0,  2'd1, 0); check("pop1_c7", 64'(count_o), 64'd7);
        check("c7_rdy", 64'(enq_ready_o), 64'd0);
        check("c7_pc0", 64'(deq_pc0_o), 64'h4);
        push(1, 32'h20, 1, 32'h24, 2'd0, 0); check("drop_c7", 64'(count_o), 64'd7);
        push(0, 32'h0,  0, 32'h0,  2'd2, 0); check("pop2_c5", 64'(count_o), 64'd5);
        check("c5_pc0", 64'(deq_pc0_o), 64'hC);

        // Flush with a simultaneous push.
        push(1, 32'h80, 1, 32'h84, 2'd2, 1);
        check("fl_count",  64'(count_o),      64'd0);
        check("fl_valid0", 64'(deq_valid0_o), 64'd0);
        check("fl_ready",  64'(enq_ready_o),  64'd1);

        // Pair split.
        push(1, 32'h10, 1, 32'h14, 2'd0, 0);
        push(1, 32'h18, 0, 32'h0,  2'd0, 0);
        check("ps_c3", 64'(count_o), 64'd3);
        push(0, 32'h0,  0, 32'h0,  2'd1, 0);
        check("ps_pc0",   64'(deq_pc0_o), 64'h14);
        check("ps_pc1",   64'(deq_pc1_o), 64'h18);
        check("ps_count", 64'(count_o),   64'd2);

        // Single younger-slot push into an empty queue.
        push(0, 32'h0, 0, 32'h0, 2'd0, 1);
        push(0, 32'h0, 1, 32'h40, 2'd0, 0);
        check("ss_pc0",    64'(deq_pc0_o),    64'h40);
        check("ss_instr0", 64'(deq_instr0_o), 64'(mk_instr(32'h40)));
        check("ss_valid1", 64'(deq_valid1_o), 64'd0);
        check("ss_count",  64'(count_o),      64'd1);

        // Empty queue ignores deq_count.
        push(0, 32'h0, 0, 32'h0, 2'd0, 1);
        push(0, 32'h0, 0, 32'h0, 2'd3, 0);
        check("empty_c0", 64'(count_o), 64'd0);

        // Wrap: steady push-2/pop-2 across the pointer wrap.
        pc = 32'h200;
        push(1, pc, 1, pc + 4, 2'd0, 0);
        pc += 8;
        exp_pc = 32'h200;
        for (int i = 0; i < 20; i++) begin
            push(1, pc, 1, pc + 4, 2'd2, 0);
            pc     += 8;
            exp_pc += 8;
            check("wrap_count", 64'(count_o),   64'd2);
            check("wrap_pc0",   64'(deq_pc0_o), 64'(exp_pc));
            check("wrap_pc1",   64'(deq_pc1_o), 64'(exp_pc + 4));
        end

        // Randomized traffic; the falling-edge compare checks everything.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 49) == 0),
                1'($urandom), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
                1'($urandom), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
                2'($urandom_range(0, 3)));
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
